// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: widths, schedule FSM encoding and bit helpers.
// Used by the message-schedule expander and its small-sigma sub-module.
package sha256_pkg;

    localparam int SHA256_WORD_W  = 32;
    localparam int SHA256_BLOCK_W = 512;
    localparam int SHA256_WIN_N   = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } sched_state_t;

    typedef logic [SHA256_WORD_W-1:0] word_t;

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (SHA256_WORD_W - n));
    endfunction

    function automatic word_t shr(input word_t x, input int unsigned n);
        return x >> n;
    endfunction

    function automatic word_t bswap32(input word_t x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // Word k of a block, W0 in the most significant slot.
    function automatic word_t block_word(
        input logic [SHA256_BLOCK_W-1:0] b,
        input int unsigned               k
    );
        return b[SHA256_BLOCK_W-1 - k*SHA256_WORD_W -: SHA256_WORD_W];
    endfunction

endpackage

// File: rtl/sha256_small_sigma.sv
// SHA-256 small sigma function, combinational.
// SEL=0 gives s0 (7,18,>>3); SEL=1 gives s1 (17,19,>>10).
module sha256_small_sigma
    import sha256_pkg::*;
#(
    parameter int SEL = 0
) (
    input  logic [31:0] x,
    output logic [31:0] y
);

    localparam int unsigned ROT_A = (SEL == 0) ? 7  : 17;
    localparam int unsigned ROT_B = (SEL == 0) ? 18 : 19;
    localparam int unsigned SHR_C = (SEL == 0) ? 3  : 10;

    assign y = rotr(x, ROT_A) ^ rotr(x, ROT_B) ^ shr(x, SHR_C);

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule expander over a 16-word sliding window.
// Define SHA256_SCHED_BYTESWAP_EN to byte-reverse each word at load.
module sha256_msg_schedule
    import sha256_pkg::*;
#(
    parameter int NUM_WORDS = 64,
    parameter int IDX_W     = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [511:0]     block_in,
    output logic             busy,
    output logic             w_valid,
    input  logic             w_ready,
    output logic [31:0]      w_out,
    output logic [IDX_W-1:0] w_idx,
    output logic             done
);

    sched_state_t     state_q;
    sched_state_t     state_d;
    word_t            win_q [SHA256_WIN_N];
    word_t            win_d [SHA256_WIN_N];
    logic [IDX_W-1:0] t_q;
    logic [IDX_W-1:0] t_d;

    word_t s0_w;
    word_t s1_w;
    word_t w_new;
    logic  accept;
    logic  last;

    function automatic word_t load_word(
        input logic [SHA256_BLOCK_W-1:0] b,
        input int unsigned               k
    );
`ifdef SHA256_SCHED_BYTESWAP_EN
        return bswap32(block_word(b, k));
`else
        return block_word(b, k);
`endif
    endfunction

    sha256_small_sigma #(.SEL(0)) u_s0 (
        .x (win_q[1]),
        .y (s0_w)
    );

    sha256_small_sigma #(.SEL(1)) u_s1 (
        .x (win_q[14]),
        .y (s1_w)
    );

    // W[t+16] from the window that currently holds W[t..t+15].
    assign w_new  = s1_w + win_q[9] + s0_w + win_q[0];
    assign accept = (state_q == RUN) && w_ready;
    assign last   = (t_q == IDX_W'(NUM_WORDS - 1));

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        for (int k = 0; k < SHA256_WIN_N; k++) begin
            win_d[k] = win_q[k];
        end
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    t_d     = '0;
                    for (int k = 0; k < SHA256_WIN_N; k++) begin
                        win_d[k] = load_word(block_in, k);
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    for (int k = 0; k < SHA256_WIN_N-1; k++) begin
                        win_d[k] = win_q[k+1];
                    end
                    win_d[SHA256_WIN_N-1] = w_new;
                    t_d = t_q + IDX_W'(1);
                    if (last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= '0;
            for (int k = 0; k < SHA256_WIN_N; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            for (int k = 0; k < SHA256_WIN_N; k++) begin
                win_q[k] <= win_d[k];
            end
        end
    end

    assign w_valid = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign busy    = (state_q != IDLE);
    assign w_out   = w_valid ? win_q[0] : '0;
    assign w_idx   = w_valid ? t_q : '0;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule against a full 64-word
// array model of the SHA-256 schedule.
module tb_sha256_msg_schedule;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [511:0] block_in;
    logic         busy;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_out;
    logic [5:0]   w_idx;
    logic         done;

    always #5 clk = ~clk;

    sha256_msg_schedule #(
        .NUM_WORDS (64),
        .IDX_W     (6)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .block_in (block_in),
        .busy     (busy),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .w_out    (w_out),
        .w_idx    (w_idx),
        .done     (done)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] msg [16];
    logic [31:0] expw [64];
    logic [31:0] got [64];
    int          ptr = 0;
    logic        fin = 1'b0;
    int          done_cnt = 0;
    int          cyc_n = 0;
    int          first_acc = 0;
    int          last_acc = 0;
    int          rmode = 0;
    int          phase = 0;
    logic        sv_valid = 1'b0;

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook schedule: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16].
    function automatic void build();
        logic [31:0] a;
        logic [31:0] b;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                expw[t] = msg[t];
            end else begin
                a = rr(expw[t-2], 17) ^ rr(expw[t-2], 19) ^ (expw[t-2] >> 10);
                b = rr(expw[t-15], 7) ^ rr(expw[t-15], 18) ^ (expw[t-15] >> 3);
                expw[t] = a + expw[t-7] + b + expw[t-16];
            end
        end
    endfunction

    function automatic logic [511:0] pack();
        logic [511:0] b;
        logic [31:0]  w;
        b = '0;
        for (int k = 0; k < 16; k++) begin
            w = msg[k];
`ifdef SHA256_SCHED_BYTESWAP_EN
            w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
            b[511 - 32*k -: 32] = w;
        end
        return b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)",
                     name, act, req, $time);
        end
    endtask

    task automatic cyc();
        logic fin_n;
        @(negedge clk);
        cyc_n++;
        fin_n = 1'b0;
        sv_valid = w_valid;
        if (!rst) begin
            chk("done", {63'd0, done}, {63'd0, fin});
            chk("busy", {63'd0, busy}, {63'd0, w_valid | done});
            if (w_valid) begin
                if (ptr > 63) begin
                    chk("extra_word", 64'd1, 64'd0);
                end else begin
                    chk("w_out", {32'd0, w_out}, {32'd0, expw[ptr]});
                    chk("w_idx", {58'd0, w_idx}, 64'(ptr));
                    if (w_ready) begin
                        got[ptr] = w_out;
                        if (ptr == 0) first_acc = cyc_n;
                        last_acc = cyc_n;
                        if (ptr == 63) fin_n = 1'b1;
                        ptr++;
                    end
                end
            end
            if (done) done_cnt++;
        end
        fin = fin_n;
        @(posedge clk);
        #1;
        phase++;
        case (rmode)
            0:       w_ready = 1'b1;
            1:       w_ready = (phase % 3 == 0);
            default: w_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic run_block(input int rm, input int inj, input int abort_at);
        int d0;
        build();
        ptr = 0;
        rmode = rm;
        d0 = done_cnt;
        block_in = pack();
        start = 1'b1;
        cyc();
        start = 1'b0;
        block_in = {16{$urandom}};
        cyc();
        chk("latency_valid", {63'd0, sv_valid}, 64'd1);
        for (int k = 0; k < 3000; k++) begin
            if (done_cnt != d0) break;
            if (abort_at >= 0 && ptr >= abort_at) break;
            if (inj != 0 && k == 4) begin
                start = 1'b1;
                block_in = {16{$urandom}};
            end else begin
                start = 1'b0;
            end
            cyc();
        end
        start = 1'b0;
        if (abort_at < 0) begin
            chk("done_pulses", 64'(done_cnt - d0), 64'd1);
            chk("word_count", 64'(ptr), 64'd64);
            cyc();
        end
    endtask

    task automatic set_abc();
        for (int k = 0; k < 16; k++) msg[k] = '0;
        msg[0]  = 32'h61626380;
        msg[15] = 32'h00000018;
    endtask

    task automatic set_rand();
        for (int k = 0; k < 16; k++) msg[k] = $urandom;
    endtask

    int dsave;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        w_ready = 1'b0;
        block_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_valid", {63'd0, w_valid}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_wout", {32'd0, w_out}, 64'd0);
        chk("rst_widx", {58'd0, w_idx}, 64'd0);
        rst = 1'b0;
        cyc();

        // T1: "abc" at full throughput
        set_abc();
        run_block(0, 0, -1);
        chk("pin_W16", {32'd0, expw[16]}, 64'h61626380);
        chk("pin_W17", {32'd0, expw[17]}, 64'h000F0000);
        chk("pin_W18", {32'd0, expw[18]}, 64'h7DA86405);
        chk("pin_W19", {32'd0, expw[19]}, 64'h600003C6);
        chk("pin_W63", {32'd0, expw[63]}, 64'h12B1EDEB);
        chk("t1_W0", {32'd0, got[0]}, 64'h61626380);
        chk("t1_W15", {32'd0, got[15]}, 64'h00000018);
        chk("t1_W63", {32'd0, got[63]}, 64'h12B1EDEB);

        // T2: all-zero block, 64 consecutive accepts
        for (int k = 0; k < 16; k++) msg[k] = '0;
        run_block(0, 0, -1);
        chk("t2_consec", 64'(last_acc - first_acc), 64'd63);
        chk("t2_W40", {32'd0, got[40]}, 64'd0);

        // T3: backpressure 1,0,0 pattern
        set_abc();
        phase = 2;
        run_block(1, 0, -1);
        chk("t3_W63", {32'd0, got[63]}, 64'h12B1EDEB);

        // T4: start pulsed during RUN is ignored
        set_abc();
        run_block(0, 1, -1);
        chk("t4_W18", {32'd0, got[18]}, 64'h7DA86405);

        // T5: reset at t=20, then a fresh block
        set_rand();
        dsave = done_cnt;
        run_block(0, 0, 20);
        chk("t5_at20", 64'(ptr), 64'd20);
        rst = 1'b1;
        #1;
        chk("t5_busy", {63'd0, busy}, 64'd0);
        chk("t5_valid", {63'd0, w_valid}, 64'd0);
        chk("t5_done", {63'd0, done}, 64'd0);
        chk("t5_wout", {32'd0, w_out}, 64'd0);
        chk("t5_widx", {58'd0, w_idx}, 64'd0);
        cyc();
        cyc();
        rst = 1'b0;
        chk("t5_no_done", 64'(done_cnt - dsave), 64'd0);
        set_rand();
        run_block(2, 0, -1);
        chk("t5_new_W0", {32'd0, got[0]}, {32'd0, msg[0]});

        // Random blocks with random backpressure
        for (int r = 0; r < 4; r++) begin
            set_rand();
            run_block(2 - (r % 2) * 2, 0, -1);
        end

`ifdef SHA256_SCHED_BYTESWAP_EN
        // T6: byte-reversed load
        set_abc();
        build();
        ptr = 0;
        rmode = 0;
        block_in = '0;
        block_in[511:480] = 32'h80636261;
        block_in[31:0]    = 32'h18000000;
        dsave = done_cnt;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (done_cnt != dsave) break;
            cyc();
        end
        chk("t6_W0", {32'd0, got[0]}, 64'h61626380);
        chk("t6_W63", {32'd0, got[63]}, 64'h12B1EDEB);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
